// File: rtl/boot_pkg.sv
// Shared definitions for the UART boot loader: controller states and the
// protocol bytes exchanged with the host.
package boot_pkg;

   typedef enum logic [2:0] {
      WAIT_SYNC,
      LEN_LO,
      LEN_HI,
      DATA,
      CHECK,
      SEND,
      RUN,
      HALT
   } boot_state_t;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam logic [7:0] ACK_BYTE  = 8'h06;
   localparam logic [7:0] NAK_BYTE  = 8'h15;

   // States in which the host owes us another byte and the byte timeout applies
   function automatic logic in_transfer(input boot_state_t s);
      return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CHECK);
   endfunction

endpackage

// File: rtl/boot_timer.sv
// Loadable down-counter that saturates at zero and flags expiry while zero.
// Reset preloads INIT_VALUE so the boot-wait window starts right out of reset.
module boot_timer #(
   parameter int               WIDTH      = 8,
   parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             enable,
   output logic             expired
);

   logic [WIDTH-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (!reset) begin
         count_reg <= INIT_VALUE;
      end else if (load) begin
         count_reg <= load_value;
      end else if (enable && (count_reg != '0)) begin
         count_reg <= count_reg - 1'b1;
      end
   end

   assign expired = (count_reg == '0);

endmodule

// File: rtl/boot_loader_ctrl.sv
// UART boot loader: receives a length-prefixed, XOR-checksummed program image,
// writes it word by word into program memory and holds the core until done.
module boot_loader_ctrl
   import boot_pkg::*;
#(
   parameter int MEMORY_SIZE         = 2048,
   parameter int BOOT_WAIT_CYCLES    = 25000000,
   parameter int BYTE_TIMEOUT_CYCLES = 2500000
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           rx_valid,
   input  logic [7:0]                     rx_data,
   input  logic                           tx_ready,
   output logic                           tx_valid,
   output logic [7:0]                     tx_data,
   output logic                           mem_we,
   output logic [$clog2(MEMORY_SIZE)-1:0] mem_addr,
   output logic [31:0]                    mem_wdata,
   output logic                           cpu_reset,
   output logic                           boot_done,
   output logic                           boot_error
);

   localparam int AW      = $clog2(MEMORY_SIZE);
   localparam int MAX_CYC = (BOOT_WAIT_CYCLES > BYTE_TIMEOUT_CYCLES) ?
                            BOOT_WAIT_CYCLES : BYTE_TIMEOUT_CYCLES;
   localparam int TW      = $clog2(MAX_CYC + 1);

   boot_state_t       state_reg, state_next;
   logic [15:0]       len_reg, len_next;
   logic [15:0]       word_idx_reg, word_idx_next;
   logic [1:0]        byte_cnt_reg, byte_cnt_next;
   logic [23:0]       shift_reg, shift_next;
   logic [7:0]        csum_reg, csum_next;
   logic [7:0]        tx_byte_reg, tx_byte_next;
   logic              error_reg, error_next;
   logic              failed_reg, failed_next;
   logic              mem_we_reg, mem_we_next;
   logic [AW-1:0]     mem_addr_reg, mem_addr_next;
   logic [31:0]       mem_wdata_reg, mem_wdata_next;

   logic              tmr_load, tmr_enable, tmr_expired;
   logic [TW-1:0]     tmr_value;
   logic [15:0]       len_word;

   assign len_word = {rx_data, len_reg[7:0]};

   // One timer covers both the post-reset boot window and the inter-byte timeout
   boot_timer #(
      .WIDTH      (TW),
      .INIT_VALUE (TW'(BOOT_WAIT_CYCLES - 1))
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .load       (tmr_load),
      .load_value (tmr_value),
      .enable     (tmr_enable),
      .expired    (tmr_expired)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg     <= WAIT_SYNC;
         len_reg       <= '0;
         word_idx_reg  <= '0;
         byte_cnt_reg  <= '0;
         shift_reg     <= '0;
         csum_reg      <= '0;
         tx_byte_reg   <= '0;
         error_reg     <= 1'b0;
         failed_reg    <= 1'b0;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
      end else begin
         state_reg     <= state_next;
         len_reg       <= len_next;
         word_idx_reg  <= word_idx_next;
         byte_cnt_reg  <= byte_cnt_next;
         shift_reg     <= shift_next;
         csum_reg      <= csum_next;
         tx_byte_reg   <= tx_byte_next;
         error_reg     <= error_next;
         failed_reg    <= failed_next;
         mem_we_reg    <= mem_we_next;
         mem_addr_reg  <= mem_addr_next;
         mem_wdata_reg <= mem_wdata_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      len_next       = len_reg;
      word_idx_next  = word_idx_reg;
      byte_cnt_next  = byte_cnt_reg;
      shift_next     = shift_reg;
      csum_next      = csum_reg;
      tx_byte_next   = tx_byte_reg;
      error_next     = error_reg;
      failed_next    = failed_reg;
      mem_we_next    = 1'b0;
      mem_addr_next  = mem_addr_reg;
      mem_wdata_next = mem_wdata_reg;
      tmr_load       = 1'b0;
      tmr_value      = TW'(BYTE_TIMEOUT_CYCLES - 1);
      tmr_enable     = in_transfer(state_reg);

      case (state_reg)
         WAIT_SYNC: begin
            tmr_enable = !failed_reg;
            if (rx_valid && (rx_data == SYNC_BYTE)) begin
               state_next = LEN_LO;
               csum_next  = '0;
               error_next = 1'b0;
               tmr_load   = 1'b1;
            end else if (!failed_reg && tmr_expired) begin
               state_next = RUN;
            end
         end
         LEN_LO: begin
            if (rx_valid) begin
               len_next   = {8'h00, rx_data};
               state_next = LEN_HI;
            end
         end
         LEN_HI: begin
            if (rx_valid) begin
               len_next      = len_word;
               word_idx_next = '0;
               byte_cnt_next = '0;
               if ({16'd0, len_word} > 32'(MEMORY_SIZE)) begin
                  tx_byte_next = NAK_BYTE;
                  error_next   = 1'b1;
                  state_next   = SEND;
               end else if (len_word == 16'd0) begin
                  state_next = CHECK;
               end else begin
                  state_next = DATA;
               end
            end
         end
         DATA: begin
            if (rx_valid) begin
               csum_next     = csum_reg ^ rx_data;
               shift_next    = {rx_data, shift_reg[23:8]};
               byte_cnt_next = byte_cnt_reg + 2'd1;
               // Fourth byte completes a little-endian word
               if (byte_cnt_reg == 2'd3) begin
                  mem_we_next    = 1'b1;
                  mem_wdata_next = {rx_data, shift_reg};
                  mem_addr_next  = word_idx_reg[AW-1:0];
                  word_idx_next  = word_idx_reg + 16'd1;
                  if (word_idx_reg == (len_reg - 16'd1)) begin
                     state_next = CHECK;
                  end
               end
            end
         end
         CHECK: begin
            if (rx_valid) begin
               tx_byte_next = (rx_data == csum_reg) ? ACK_BYTE : NAK_BYTE;
               error_next   = (rx_data != csum_reg);
               state_next   = SEND;
            end
         end
         SEND: begin
            if (tx_ready) begin
               state_next = error_reg ? HALT : RUN;
            end
         end
         HALT: begin
            failed_next = 1'b1;
            state_next  = WAIT_SYNC;
         end
         default: begin
            state_next = state_reg;
         end
      endcase

      if (in_transfer(state_reg)) begin
         if (rx_valid) begin
            tmr_load = 1'b1;
         end else if (tmr_expired) begin
            tx_byte_next = NAK_BYTE;
            error_next   = 1'b1;
            state_next   = SEND;
         end
      end
   end

   always_comb begin
      tx_valid  = (state_reg == SEND);
      cpu_reset = (state_reg != RUN);
      boot_done = (state_reg == RUN);
   end

   assign tx_data    = tx_byte_reg;
   assign mem_we     = mem_we_reg;
   assign mem_addr   = mem_addr_reg;
   assign mem_wdata  = mem_wdata_reg;
   assign boot_error = error_reg;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Scoreboard bench for boot_loader_ctrl: a stream-level model queues expected
// memory writes and reply bytes, a negedge monitor pops and compares them.
module tb_boot_loader_ctrl;

   localparam int MEM = 2048;
   localparam int BW  = 100;
   localparam int BT  = 40;
   localparam int AW  = $clog2(MEM);

   typedef logic [7:0] byte_q_t[$];
   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          rx_valid = 1'b0;
   logic [7:0]    rx_data = 8'h00;
   logic          tx_ready = 1'b0;
   logic          tx_valid;
   logic [7:0]    tx_data;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          cpu_reset, boot_done, boot_error;

   int  n_checks = 0;
   int  n_pass   = 0;
   int  tx_mode  = 0;
   wr_t exp_wr[$];
   logic [7:0] exp_tx[$];
   logic       prev_valid = 1'b0, prev_hs = 1'b0;
   logic [7:0] prev_data = 8'h00;

   boot_loader_ctrl #(
      .MEMORY_SIZE         (MEM),
      .BOOT_WAIT_CYCLES    (BW),
      .BYTE_TIMEOUT_CYCLES (BT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .tx_ready   (tx_ready),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .cpu_reset  (cpu_reset),
      .boot_done  (boot_done),
      .boot_error (boot_error)
   );

   always #5 clk = ~clk;

   task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Reference model: interprets a host byte stream (sync byte first) by the
   // protocol rules and queues what the loader must produce.
   task automatic expect_stream(input byte_q_t s, output bit ok);
      int n;
      logic [7:0] cs;
      ok = 1'b0;
      cs = 8'h00;
      if (s.size() < 3) begin
         exp_tx.push_back(8'h15);
         return;
      end
      n = int'(s[1]) | (int'(s[2]) << 8);
      if (n > MEM) begin
         exp_tx.push_back(8'h15);
         return;
      end
      for (int w = 0; w < n; w++) begin
         int b;
         b = 3 + 4 * w;
         if (b + 3 >= s.size()) break;
         exp_wr.push_back('{addr: AW'(w), data: {s[b+3], s[b+2], s[b+1], s[b]}});
         cs = cs ^ s[b] ^ s[b+1] ^ s[b+2] ^ s[b+3];
      end
      if (s.size() <= 3 + 4 * n) begin
         exp_tx.push_back(8'h15);
      end else if (s[3 + 4 * n] == cs) begin
         exp_tx.push_back(8'h06);
         ok = 1'b1;
      end else begin
         exp_tx.push_back(8'h15);
      end
   endtask

   function automatic byte_q_t make_stream(input int n, input bit good);
      byte_q_t s;
      logic [7:0] cs, b;
      cs = 8'h00;
      s.push_back(8'hA5);
      s.push_back(8'(n));
      s.push_back(8'(n >> 8));
      for (int i = 0; i < 4 * n; i++) begin
         b = 8'($urandom);
         cs ^= b;
         s.push_back(b);
      end
      s.push_back(good ? cs : cs ^ 8'($urandom_range(1, 255)));
      return s;
   endfunction

   // Scoreboard monitor
   always @(negedge clk) begin
      if (mem_we) begin
         if (exp_wr.size() == 0) begin
            check(1'b0, "unexpected_mem_we", 32'(mem_addr), 32'd0);
         end else begin
            wr_t e;
            e = exp_wr.pop_front();
            $display("mem write addr=%0d data=0x%08h", mem_addr, mem_wdata);
            check(mem_addr == e.addr, "mem_addr", 32'(mem_addr), 32'(e.addr));
            check(mem_wdata == e.data, "mem_wdata", mem_wdata, e.data);
         end
      end
      if (prev_valid && !prev_hs) begin
         check(tx_valid && (tx_data == prev_data), "tx_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, prev_data});
      end
      if (tx_valid && tx_ready) begin
         if (exp_tx.size() == 0) begin
            check(1'b0, "unexpected_tx", 32'(tx_data), 32'd0);
         end else begin
            logic [7:0] e;
            e = exp_tx.pop_front();
            $display("tx byte 0x%02h", tx_data);
            check(tx_data == e, "tx_data", 32'(tx_data), 32'(e));
         end
      end
      prev_valid = tx_valid;
      prev_hs    = tx_ready;
      prev_data  = tx_data;
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (tx_mode)
            0:       tx_ready = 1'($urandom_range(0, 1));
            1:       tx_ready = 1'b0;
            default: tx_ready = 1'b1;
         endcase
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      tick(1);
      reset    = 1'b0;
      rx_valid = 1'b0;
      tick(2);
      check(cpu_reset && !tx_valid && !mem_we && !boot_done && !boot_error && (tx_data == 8'h00),
            "reset_flags", {19'd0, cpu_reset, tx_valid, mem_we, boot_done, boot_error, tx_data},
            {19'd0, 5'b10000, 8'h00});
      check((mem_addr == '0) && (mem_wdata == 32'd0), "reset_mem", mem_wdata | 32'(mem_addr), 32'd0);
      reset = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_valid = 1'b1;
      rx_data  = b;
      tick(1);
      rx_valid = 1'b0;
      tick($urandom_range(0, gap));
   endtask

   task automatic send_stream(input byte_q_t s);
      foreach (s[i]) send_byte(s[i], 2);
   endtask

   task automatic wait_tx_drained(input string name);
      int c;
      c = 0;
      while (exp_tx.size() != 0 && c < 400) begin
         tick(1);
         c++;
      end
      if (exp_tx.size() != 0) begin
         check(1'b0, name, 32'(exp_tx.size()), 32'd0);
         exp_tx.delete();
      end
      tick(2);
   endtask

   task automatic check_final(input bit ok, input string name);
      if (ok) check(boot_done && !cpu_reset && !boot_error, name, {29'd0, boot_done, cpu_reset, boot_error}, 32'b100);
      else    check(!boot_done && cpu_reset && boot_error, name, {29'd0, boot_done, cpu_reset, boot_error}, 32'b011);
      check(exp_wr.size() == 0, "pending_writes", 32'(exp_wr.size()), 32'd0);
      exp_wr.delete();
   endtask

   initial begin
      byte_q_t s;
      bit ok;
      int cyc;

      // No traffic: the core is released when the boot window closes
      do_reset();
      cyc = 0;
      while (cpu_reset && cyc < BW + 50) begin
         tick(1);
         cyc++;
      end
      $display("boot window release after %0d cycles", cyc);
      check(cyc == BW, "boot_wait_release", 32'(cyc), 32'(BW));
      s = make_stream(2, 1'b1);
      send_stream(s);
      tick(5);
      check(boot_done && !cpu_reset, "run_ignores_rx", {30'd0, boot_done, cpu_reset}, 32'b10);

      // Two-word image; 0x88 is the XOR of the eight data bytes
      do_reset();
      s = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
      expect_stream(s, ok);
      send_stream(s);
      wait_tx_drained("ack_timeout");
      check_final(ok, "good_image_status");

      // Same image, wrong checksum: core must stay held past the boot window
      do_reset();
      s[11] = 8'h09;
      expect_stream(s, ok);
      send_stream(s);
      wait_tx_drained("nak_timeout");
      check_final(ok, "bad_csum_status");
      tick(BW + 20);
      check(cpu_reset && boot_error, "held_after_failure", {30'd0, cpu_reset, boot_error}, 32'b11);

      // Retry without reset succeeds and clears the error
      s = make_stream(3, 1'b1);
      expect_stream(s, ok);
      send_stream(s);
      wait_tx_drained("retry_timeout");
      check_final(ok, "retry_status");

      // Oversized length is rejected before any data
      do_reset();
      s = '{8'hA5, 8'h01, 8'h10};
      expect_stream(s, ok);
      send_stream(s);
      wait_tx_drained("oversize_timeout");
      check_final(ok, "oversize_status");

      // Host stops mid-word: byte timeout produces a NAK
      do_reset();
      s = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22};
      expect_stream(s, ok);
      send_stream(s);
      wait_tx_drained("byte_timeout_nak");
      check_final(ok, "byte_timeout_status");

      // Transmitter stalls for 20 cycles in SEND
      do_reset();
      tx_mode = 1;
      s = make_stream(1, 1'b1);
      expect_stream(s, ok);
      send_stream(s);
      cyc = 0;
      while (!tx_valid && cyc < 50) begin
         tick(1);
         cyc++;
      end
      tick(20);
      check(tx_valid && exp_tx.size() == 1, "stall_hold", {30'd0, tx_valid, exp_tx.size() == 1}, 32'b11);
      tx_mode = 2;
      wait_tx_drained("stall_release");
      tx_mode = 0;
      check_final(ok, "stall_status");

      // Reset in the middle of a transfer, then a clean load
      do_reset();
      send_byte(8'hA5, 1);
      send_byte(8'h02, 1);
      send_byte(8'h00, 1);
      send_byte(8'h11, 1);
      send_byte(8'h22, 1);
      do_reset();
      tick(4);
      s = make_stream(2, 1'b1);
      expect_stream(s, ok);
      send_stream(s);
      wait_tx_drained("after_abort_timeout");
      check_final(ok, "after_abort_status");

      // Randomized images with leading noise
      for (int it = 0; it < 10; it++) begin
         do_reset();
         repeat ($urandom_range(0, 3)) send_byte(8'($urandom_range(0, 8'hA4)), 3);
         s = make_stream($urandom_range(0, 6), $urandom_range(0, 3) != 0);
         expect_stream(s, ok);
         send_stream(s);
         wait_tx_drained("random_timeout");
         check_final(ok, "random_status");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
